gate_truth_checker: RTL and testbench

Sequential truth-table checker for 2-input gate blocks, such as OR built from two NOR gates.
- It is the consuming end of a gate test: it drives the gate's a/b inputs through all four combinations and reads back y.
- It compares each y against a parameterised expected table and reports pass/fail plus a per-vector error map.
- It sits beside a gate instance as a self-check wrapper, replacing open-loop $stop-style stimulus.

---
 rtl/gate_chk_pkg.sv | 18 +
 rtl/gate_chk_settle_cnt.sv | 26 ++
 rtl/gate_truth_checker.sv | 135 +++++++++++++
 tb/tb_gate_truth_checker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the 2-input gate truth-table checker.
// Table bit index is {a,b}.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// 4-bit loadable down-counter that times how long each vector is held before sampling.
// Stops at zero; zero is a combinational flag of the count register.
module gate_chk_settle_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives a 2-input gate through vectors 00,01,10,11, samples y after a settle time and
// compares it against EXP_TABLE, reporting pass, mismatch count and a per-vector error map.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0]  EXP_TABLE     = TT_OR,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_map
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [2:0] err_count_nxt;
  logic [3:0] err_map_nxt;
  logic       cnt_load, cnt_en, cnt_zero;
  logic       mismatch;

  gate_chk_settle_cnt u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_map   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      a_out     <= a_nxt;
      b_out     <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_count_nxt;
      err_map   <= err_map_nxt;
    end
  end

  assign mismatch = (y_in != EXP_TABLE[idx]);

  // Outputs are registered, so each branch computes the value they take after this edge.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    a_nxt         = a_out;
    b_nxt         = b_out;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    pass_nxt      = pass;
    err_count_nxt = err_count;
    err_map_nxt   = err_map;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;

    case (state)
      IDLE: begin
        a_nxt    = 1'b0;
        b_nxt    = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt     = DRIVE;
          idx_nxt       = '0;
          cnt_load      = 1'b1;
          busy_nxt      = 1'b1;
          pass_nxt      = 1'b0;
          err_count_nxt = '0;
          err_map_nxt   = '0;
        end
      end

      DRIVE: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_nxt = SAMPLE;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          err_map_nxt[idx] = 1'b1;
          err_count_nxt    = err_count + 3'd1;
        end
        if (idx == 2'd3) begin
          // pass must include the mismatch recorded on this final sample
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (err_count_nxt == '0);
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
        end else begin
          state_nxt      = DRIVE;
          idx_nxt        = idx + 2'd1;
          {a_nxt, b_nxt} = idx + 2'd1;
          cnt_load       = 1'b1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench: two checker instances (OR/settle 2 and XOR/settle 1) driving
// table-defined gates, checked against a vector-level model of the expected run.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  logic clk;
  logic rst_n;
  logic start;
  logic sel;
  logic or_from_nor;
  logic [3:0] tt0, tt1;

  logic start0, start1, y0, y1;
  logic a0, b0, busy0, done0, pass0;
  logic a1, b1, busy1, done1, pass1;
  logic [2:0] errc0, errc1;
  logic [3:0] errm0, errm1;

  logic a_s, b_s, busy_s, done_s, pass_s;
  logic [2:0] errc_s;
  logic [3:0] errm_s;

  int unsigned n_checks;
  int unsigned n_fail;

  logic nor_1;

  assign start0 = start && !sel;
  assign start1 = start && sel;
  assign nor_1  = ~(a0 | b0);
  assign y0     = or_from_nor ? ~(nor_1 | nor_1) : tt0[{a0, b0}];
  assign y1     = tt1[{a1, b1}];

  gate_truth_checker dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .y_in      (y0),
    .a_out     (a0),
    .b_out     (b0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .err_count (errc0),
    .err_map   (errm0)
  );

  gate_truth_checker #(
    .EXP_TABLE     (TT_XOR),
    .SETTLE_CYCLES (1)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .y_in      (y1),
    .a_out     (a1),
    .b_out     (b1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (errc1),
    .err_map   (errm1)
  );

  always_comb begin
    a_s    = sel ? a1    : a0;
    b_s    = sel ? b1    : b0;
    busy_s = sel ? busy1 : busy0;
    done_s = sel ? done1 : done0;
    pass_s = sel ? pass1 : pass0;
    errc_s = sel ? errc1 : errc0;
    errm_s = sel ? errm1 : errm0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs(input bit which);
    if (which)
      return {21'd0, a1, b1, busy1, done1, pass1, errc1, errm1};
    return {21'd0, a0, b0, busy0, done0, pass0, errc0, errm0};
  endfunction

  // Model: every vector is held settle+1 cycles, done after 4*(settle+1) edges,
  // err_map is the XOR of gate and expected tables.
  task automatic run(input bit which, input logic [3:0] gate_tt, input bit glitch);
    int unsigned settle  = which ? 1 : 2;
    logic [3:0]  exp_tab = which ? TT_XOR : TT_OR;
    logic [3:0]  exp_map = gate_tt ^ exp_tab;
    int unsigned held[4] = '{default: 0};
    int unsigned lat     = 0;
    sel = which;
    if (which) tt1 = gate_tt; else tt0 = gate_tt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_eq("busy_at_accept", busy_s, 1);
    chk_eq("pass_cleared", pass_s, 0);
    chk_eq("errc_cleared", errc_s, 0);
    chk_eq("errm_cleared", errm_s, 0);
    for (int n = 1; n <= 100; n++) begin
      held[{a_s, b_s}]++;
      start = (glitch && (n == 5 || n == 6));
      tick();
      if (done_s) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chk_eq("done_latency", lat, 4 * (settle + 1));
    for (int k = 0; k < 4; k++)
      chk_eq($sformatf("held_vec%0d", k), held[k], settle + 1);
    chk_eq("err_map", errm_s, exp_map);
    chk_eq("err_count", errc_s, $countones(exp_map));
    chk_eq("pass", pass_s, (exp_map == 4'd0));
    tick();
    chk_eq("done_pulse_end", done_s, 0);
    chk_eq("busy_after_done", busy_s, 0);
    repeat (3) tick();
    chk_eq("hold_err_map", errm_s, exp_map);
    chk_eq("hold_pass", pass_s, (exp_map == 4'd0));
    chk_eq("idle_ab", {a_s, b_s}, 0);
  endtask

  // start held high across DONE: second run accepted one IDLE cycle later, results cleared
  task automatic held_run(input logic [3:0] gate_tt);
    int unsigned lat = 0;
    logic [3:0]  exp_map = gate_tt ^ TT_OR;
    sel   = 1'b0;
    tt0   = gate_tt;
    start = 1'b1;
    tick();
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (done0) begin
        lat = n;
        break;
      end
    end
    chk_eq("held1_latency", lat, 12);
    chk_eq("held1_pass", pass0, (exp_map == 4'd0));
    tick();
    chk_eq("held_idle_busy", busy0, 0);
    tick();
    chk_eq("held2_busy", busy0, 1);
    chk_eq("held2_pass_clr", pass0, 0);
    chk_eq("held2_errc_clr", errc0, 0);
    chk_eq("held2_errm_clr", errm0, 0);
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (done0) begin
        lat = n;
        break;
      end
    end
    chk_eq("held2_latency", lat, 12);
    chk_eq("held2_errm", errm0, exp_map);
    tick();
  endtask

  initial begin
    logic [3:0] rtt;
    bit         w;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    sel         = 1'b0;
    or_from_nor = 1'b0;
    tt0         = TT_OR;
    tt1         = TT_XOR;
    #1;
    chk_eq("reset_outs0", all_outs(0), 0);
    chk_eq("reset_outs1", all_outs(1), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    or_from_nor = 1'b1;
    run(0, TT_OR, 0);
    or_from_nor = 1'b0;
    run(0, 4'b0000, 0);
    run(0, TT_NOR, 0);
    run(1, TT_XOR, 0);
    run(1, TT_AND, 0);
    run(0, TT_OR, 1);

    sel   = 1'b0;
    tt0   = TT_OR;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk_eq("mid_run_vec2", {a0, b0}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("async_reset_outs0", all_outs(0), 0);
    repeat (2) tick();
    chk_eq("reset_hold_outs0", all_outs(0), 0);
    rst_n = 1'b1;
    tick();
    run(0, TT_OR, 0);

    held_run(TT_OR);
    held_run(TT_NAND);

    for (int i = 0; i < 16; i++) begin
      w   = 1'($urandom_range(0, 1));
      rtt = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rtt = w ? TT_XOR : TT_OR;
      run(w, rtt, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
